wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- write-back pipeline stage
//
// Purpose
//   Takes the instruction sitting in MEM, forms the register-file write value
//   (ALU result, comparator bit, U immediate, PC+4, or an aligned and extended
//   load result), and registers it so that the register-file write port is
//   driven straight from flops one cycle after MEM.
//
//   A "fresh" bit marks a register that was loaded on the previous edge with
//   a live, unflushed instruction. valid_wb and load_regfile_wb are qualified
//   by it, so an instruction retires once even when the stage is then held
//   by stall for many cycles.
//
// Handshake
//   There is no valid/ready pair. MEM presents an instruction with valid_mem.
//   The stage accepts it on every rising edge where stall=0. flush=1 on that
//   edge still loads the data fields but suppresses the write and the retire
//   pulse. stall=1 holds every captured field and drops the pulse.
//
// Parameters
//   CNT_WIDTH           width of the retired-instruction counter
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-low reset
//   valid_mem           MEM holds a live instruction
//   stall               hold the WB register
//   flush               squash the instruction currently in MEM
//   rd_mem[4:0]         destination register index
//   load_regfile_mem    instruction writes the register file
//   regfilemux_sel_mem  write-value select (encodings below)
//   alu_out_mem[31:0]   ALU result; bits [1:0] also form the load byte offset
//   u_imm_mem[31:0]     U-type immediate
//   pc_mem[31:0]        instruction PC
//   rdata_mem[31:0]     raw data-memory read word
//   br_en_mem           comparator result
//   rd_wb[4:0]          register-file write index
//   load_regfile_wb     register-file write enable
//   regfilemux_out_wb   register-file write data
//   valid_wb            one-cycle retire pulse
//   retire_count        retired-instruction count (WB_RETIRE_CNT_EN only)
//
// Configuration
//   WB_RETIRE_CNT_EN    when defined, adds the retire_count port and counter
//
// Select encodings
//   0 alu_out, 1 br_en, 2 u_imm, 3 pc_plus4, 4 lw, 5 lb, 6 lbu, 7 lh, 8 lhu.
//   Any other code falls back to alu_out.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_mem,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [4:0]           rd_mem,
  input  logic                 load_regfile_mem,
  input  logic [3:0]           regfilemux_sel_mem,
  input  logic [31:0]          alu_out_mem,
  input  logic [31:0]          u_imm_mem,
  input  logic [31:0]          pc_mem,
  input  logic [31:0]          rdata_mem,
  input  logic                 br_en_mem,
  output logic [4:0]           rd_wb,
  output logic                 load_regfile_wb,
  output logic [31:0]          regfilemux_out_wb,
  output logic                 valid_wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] retire_count
`endif
);

  localparam logic [3:0] SEL_ALU_OUT  = 4'd0;
  localparam logic [3:0] SEL_BR_EN    = 4'd1;
  localparam logic [3:0] SEL_U_IMM    = 4'd2;
  localparam logic [3:0] SEL_PC_PLUS4 = 4'd3;
  localparam logic [3:0] SEL_LW       = 4'd4;
  localparam logic [3:0] SEL_LB       = 4'd5;
  localparam logic [3:0] SEL_LBU      = 4'd6;
  localparam logic [3:0] SEL_LH       = 4'd7;
  localparam logic [3:0] SEL_LHU      = 4'd8;

  // -------------------------------------------------------------------------
  // Load alignment: pick the addressed byte / halfword out of the read word.
  // Byte 0 is bits [7:0]; halfword selection looks only at address bit 1.
  // -------------------------------------------------------------------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = rdata_mem[7:0];
    case (alu_out_mem[1:0])
      2'd0:    load_byte = rdata_mem[7:0];
      2'd1:    load_byte = rdata_mem[15:8];
      2'd2:    load_byte = rdata_mem[23:16];
      default: load_byte = rdata_mem[31:24];
    endcase
  end

  always_comb begin
    load_half = rdata_mem[15:0];
    if (alu_out_mem[1]) begin
      load_half = rdata_mem[31:16];
    end
  end

  // -------------------------------------------------------------------------
  // Write-value mux, evaluated in MEM so the WB outputs are pure flop outputs.
  // -------------------------------------------------------------------------
  logic [31:0] wdata_d;
  logic [31:0] pc_plus4;

  // 32-bit add drops the carry, so PC 0xFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc_mem + 32'd4;

  always_comb begin
    wdata_d = alu_out_mem;
    case (regfilemux_sel_mem)
      SEL_ALU_OUT:  wdata_d = alu_out_mem;
      SEL_BR_EN:    wdata_d = {31'd0, br_en_mem};
      SEL_U_IMM:    wdata_d = u_imm_mem;
      SEL_PC_PLUS4: wdata_d = pc_plus4;
      SEL_LW:       wdata_d = rdata_mem;
      SEL_LB:       wdata_d = {{24{load_byte[7]}}, load_byte};
      SEL_LBU:      wdata_d = {24'd0, load_byte};
      SEL_LH:       wdata_d = {{16{load_half[15]}}, load_half};
      SEL_LHU:      wdata_d = {16'd0, load_half};
      default:      wdata_d = alu_out_mem;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state for the WB register
  // -------------------------------------------------------------------------
  logic [4:0]  rd_q,    rd_d;
  logic        load_q,  load_d;
  logic [31:0] wdata_q, wdata_q_d;
  logic        fresh_q, fresh_d;

  always_comb begin
    rd_d      = rd_q;
    load_d    = load_q;
    wdata_q_d = wdata_q;
    // A held register never re-announces its instruction; flush is
    // irrelevant while stalled because nothing is captured.
    fresh_d   = 1'b0;
    if (!stall) begin
      rd_d      = rd_mem;
      load_d    = load_regfile_mem;
      wdata_q_d = wdata_d;
      fresh_d   = valid_mem & ~flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= 5'd0;
      load_q  <= 1'b0;
      wdata_q <= 32'd0;
      fresh_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      load_q  <= load_d;
      wdata_q <= wdata_q_d;
      fresh_q <= fresh_d;
    end
  end

  assign rd_wb             = rd_q;
  assign regfilemux_out_wb = wdata_q;
  assign valid_wb          = fresh_q;
  // x0 is hard-wired zero, so a write to it is never issued.
  assign load_regfile_wb   = fresh_q & load_q & (rd_q != 5'd0);

  // -------------------------------------------------------------------------
  // Optional retired-instruction counter
  // -------------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  // Counts every edge on which the retire pulse is high; wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (fresh_q) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_count = retire_cnt_q;
`else
  // Counter absent in this build; the parameter is kept for a uniform
  // instantiation interface.
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule
